// File: rtl/fp16_dot_fma_driver_pkg.sv
// Shared constants and FSM state encoding for the FP16 dot-product FMA driver.
package fp16_dot_fma_driver_pkg;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {ACCUM, DRAIN, REDUCE, OUT} state_t;
endpackage

// File: rtl/fp16_dot_fma_driver_fma_tag_pipe.sv
// fma_tag_pipe: LAT-deep shift register that travels alongside the external FMA.
// Each issue pushes {valid, tag}; the entry leaving the last stage is the
// return the driver expects to see on fma_out_valid in that same cycle.
//   clk, rst        clock, async active-high reset (flushes all in-flight tags)
//   in_valid/in_tag issue strobe and partial-sum slot of the issue
//   ret_valid/tag   expected return strobe and its slot
module fma_tag_pipe #(
  parameter int LAT   = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             ret_valid,
  output logic [TAG_W-1:0] ret_tag
);
  logic [LAT-1:0]            vld_pipe;
  logic [LAT-1:0][TAG_W-1:0] tag_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      tag_pipe[0] <= in_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign ret_valid = vld_pipe[LAT-1];
  assign ret_tag   = tag_pipe[LAT-1];
endmodule

// File: rtl/fp16_dot_fma_driver.sv
// fp16_dot_fma_driver: streams FP16 (a,b) pairs into an external fixed-latency
// FMA, interleaving FMA_LAT partial sums to hide latency, then folds the
// partials through the same FMA (x*1.0 + acc) and presents one dot product.
//   s_valid/s_ready/s_a/s_b/s_last   element stream in
//   fma_in_valid/fma_a/b/c           issue to FMA (zero when not issuing)
//   fma_out_valid/fma_out            FMA return
//   m_valid/m_ready/m_data/m_count   result out, held until accepted
//   err                              sticky return/slot disagreement
module fp16_dot_fma_driver
  import fp16_dot_fma_driver_pkg::*;
#(
  parameter int FMA_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_a,
  input  logic [15:0]      s_b,
  input  logic             s_last,
  output logic             fma_in_valid,
  output logic [15:0]      fma_a,
  output logic [15:0]      fma_b,
  output logic [15:0]      fma_c,
  input  logic             fma_out_valid,
  input  logic [15:0]      fma_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic [CNT_W-1:0] m_count,
  output logic             err
);
  localparam int SLOT_W = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FMA_LAT - 1);

  state_t                    state, state_nxt;
  logic [FMA_LAT-1:0][15:0]  partial;
  logic [FMA_LAT-1:0]        pending, ret_mask;
  logic [SLOT_W-1:0]         slot, idx, tag_in, ret_tag;
  logic [15:0]               acc;
  logic [SLOT_W:0]           quiet;
  logic                      busy, run, ret_valid, slot_ret, hs, drained;

  fma_tag_pipe #(.LAT(FMA_LAT), .TAG_W(SLOT_W)) u_tag_pipe (
    .clk(clk), .rst(rst), .in_valid(fma_in_valid), .in_tag(tag_in),
    .ret_valid(ret_valid), .ret_tag(ret_tag)
  );

  always_comb begin
    ret_mask = '0;
    if (ret_valid) ret_mask[ret_tag] = 1'b1;
  end

  // Only registered state feeds s_ready; the slot returning this cycle frees it
  // because its result is bypassed straight into fma_c.
  assign slot_ret = ret_valid && (ret_tag == slot);
  assign drained  = ((pending & ~ret_mask) == '0);
  assign s_ready  = run && (state == ACCUM) && (!pending[slot] || slot_ret);
  assign hs       = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fma_in_valid = 1'b0;
    fma_a        = FP16_ZERO;
    fma_b        = FP16_ZERO;
    fma_c        = FP16_ZERO;
    tag_in       = '0;
    case (state)
      ACCUM: if (hs) begin
        fma_in_valid = 1'b1;
        fma_a        = s_a;
        fma_b        = s_b;
        fma_c        = slot_ret ? fma_out : partial[slot];
        tag_in       = slot;
        if (s_last) state_nxt = DRAIN;
      end
      DRAIN: if (drained) state_nxt = REDUCE;
      REDUCE: begin
        if (!busy) begin
          fma_in_valid = 1'b1;
          fma_a        = partial[idx];
          fma_b        = FP16_ONE;
          fma_c        = acc;
        end else if (ret_valid && idx == LAST_SLOT) begin
          state_nxt = OUT;
        end
      end
      OUT: if (m_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partial <= '0;
      pending <= '0;
      slot    <= '0;
      idx     <= '0;
      acc     <= FP16_ZERO;
      busy    <= 1'b0;
      run     <= 1'b0;
      // Returns for issues made before reset can still arrive for up to
      // FMA_LAT cycles; the checker stays blind until they have drained.
      quiet   <= (SLOT_W+1)'(FMA_LAT);
      m_valid <= 1'b0;
      m_data  <= FP16_ZERO;
      m_count <= '0;
      err     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (quiet != '0) quiet <= quiet - 1'b1;
      if (quiet == '0 && ret_valid != fma_out_valid) err <= 1'b1;
      if (ret_valid) pending[ret_tag] <= 1'b0;
      case (state)
        ACCUM: begin
          if (ret_valid) partial[ret_tag] <= fma_out;
          if (hs) begin
            pending[slot] <= 1'b1;  // overrides a same-cycle clear of this slot
            slot          <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            if (m_count != '1) m_count <= m_count + 1'b1;
          end
        end
        DRAIN: begin
          if (ret_valid) partial[ret_tag] <= fma_out;
          if (drained) begin
            idx  <= SLOT_W'(1);
            acc  <= (ret_valid && ret_tag == '0) ? fma_out : partial[0];
            busy <= 1'b0;
          end
        end
        REDUCE: begin
          if (!busy) begin
            busy <= 1'b1;
          end else if (ret_valid) begin
            acc  <= fma_out;
            busy <= 1'b0;
            idx  <= idx + 1'b1;
            if (idx == LAST_SLOT) begin
              m_data  <= fma_out;
              m_valid <= 1'b1;
            end
          end
        end
        OUT: if (m_ready) begin
          m_valid <= 1'b0;
          partial <= '0;
          m_count <= '0;
          slot    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_dot_fma_driver.sv
// Directed bench for fp16_dot_fma_driver with a behavioural 4-cycle FP16 FMA.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fp16_dot_fma_driver;
  localparam int LAT = 4;
  localparam int CW  = 16;
  localparam logic [15:0] ONE  = 16'h3C00;
  localparam logic [15:0] TWO  = 16'h4000;
  localparam logic [15:0] THR  = 16'h4200;
  localparam logic [15:0] HALF = 16'h3800;

  logic          clk = 1'b0, rst = 1'b1;
  logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, inject = 1'b0;
  logic [15:0]   s_a = '0, s_b = '0;
  logic          s_ready, fma_in_valid, fma_out_valid, m_valid, err;
  logic [15:0]   fma_a, fma_b, fma_c, fma_out, m_data;
  logic [CW-1:0] m_count;
  int            checks = 0, failures = 0;

  always #5 clk = ~clk;

  fp16_dot_fma_driver #(.FMA_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_last(s_last), .fma_in_valid(fma_in_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_out_valid(fma_out_valid), .fma_out(fma_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_count(m_count), .err(err)
  );

  // FP16FMA model: exact for the small values used here; not reset, so
  // issues in flight across a driver reset still come back.
  function automatic real h2r(input logic [15:0] h);
    real r;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) r = real'(h[9:0]) / 16777216.0;
    else begin
      r = (1024.0 + real'(h[9:0])) / 1024.0;
      for (int i = 15; i < e; i++) r = r * 2.0;
      for (int i = e; i < 15; i++) r = r / 2.0;
    end
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  v;
    int   e, m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    v = s ? -r : r;
    e = 15;
    while (v >= 2.0 && e < 30) begin v = v / 2.0; e++; end
    while (v < 1.0 && e > 1) begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * 1024.0 + 0.5);
    return {s, e[4:0], m[9:0]};
  endfunction

  logic [3:0]       fv = '0;
  logic [3:0][15:0] fd = '0;
  always @(posedge clk) begin
    fv <= {fv[2:0], fma_in_valid};
    fd <= {fd[2:0], r2h(h2r(fma_a) * h2r(fma_b) + h2r(fma_c))};
  end
  assign fma_out_valid = fv[3] | inject;
  assign fma_out       = fd[3];

  // Stimulus helpers (called at a falling edge, return at a falling edge).
  task automatic push(input logic [15:0] a, input logic [15:0] b, input bit last, output int waited);
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last; waited = 0;
    while (!s_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!s_ready) waited = -1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_result(output bit got);
    int g = 0;
    while (!m_valid && g < 200) begin @(negedge clk); g++; end
    got = m_valid;
  endtask

  task automatic accept();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({s_ready, fma_in_valid, fma_a, fma_b, fma_c, m_valid, m_data, m_count, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b iv=%b a=%h b=%h c=%h mv=%b md=%h mc=%0d err=%b want all 0",
               s_ready, fma_in_valid, fma_a, fma_b, fma_c, m_valid, m_data, m_count, err);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int w, stalls = 0, tmo = 0;
    bit got;
    for (int i = 0; i < 8; i++) begin
      push(ONE, ONE, i == 7, w);
      if (w < 0) tmo++; else stalls += w;
    end
    checks++;
    if (stalls != 0 || tmo != 0) begin
      failures++; $display("FAIL b2b_no_stall: got stalls=%0d timeouts=%0d want 0/0", stalls, tmo);
    end
    wait_result(got);
    checks++;
    if (!got) begin failures++; $display("FAIL b2b_result_timeout: got m_valid=0 want 1"); end
    checks++;
    if (m_data !== 16'h4800) begin failures++; $display("FAIL b2b_data: got %h want 4800", m_data); end
    checks++;
    if (m_count !== 16'd8) begin failures++; $display("FAIL b2b_count: got %0d want 8", m_count); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b want 0", err); end
    accept();
    checks++;
    if (m_valid !== 1'b0 || m_count !== '0) begin
      failures++; $display("FAIL b2b_accept: got m_valid=%b m_count=%0d want 0/0", m_valid, m_count);
    end
  endtask

  task automatic test_single();
    int w;
    bit got;
    push(TWO, THR, 1'b1, w);
    wait_result(got);
    checks++;
    if (!got || w < 0) begin failures++; $display("FAIL single_timeout: got m_valid=%b wait=%0d", m_valid, w); end
    checks++;
    if (m_data !== 16'h4600) begin failures++; $display("FAIL single_data: got %h want 4600", m_data); end
    checks++;
    if (m_count !== 16'd1) begin failures++; $display("FAIL single_count: got %0d want 1", m_count); end
    accept();
  endtask

  task automatic test_toggle();
    int w, stalls = 0, idle_low = 0;
    bit got;
    for (int i = 0; i < 6; i++) begin
      push(HALF, TWO, i == 5, w);
      if (w != 0) stalls++;
      if (i < 5) begin
        if (!s_ready) idle_low++;
        @(negedge clk);
      end
    end
    checks++;
    if (stalls != 0 || idle_low != 0) begin
      failures++; $display("FAIL toggle_ready: got stalls=%0d idle_low=%0d want 0/0", stalls, idle_low);
    end
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL toggle_drain_ready: got %b want 0", s_ready); end
    wait_result(got);
    checks++;
    if (!got || m_data !== 16'h4600 || m_count !== 16'd6) begin
      failures++; $display("FAIL toggle_result: got v=%b d=%h c=%0d want 1/4600/6", m_valid, m_data, m_count);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int w, bad = 0;
    bit got;
    for (int i = 0; i < 4; i++) push(ONE, ONE, i == 3, w);
    wait_result(got);
    checks++;
    if (!got) begin failures++; $display("FAIL bp_timeout: got m_valid=0 want 1"); end
    s_valid = 1'b1; s_a = TWO; s_b = TWO;  // offered but must not be taken
    for (int i = 0; i < 10; i++) begin
      if (m_valid !== 1'b1 || m_data !== 16'h4400 || m_count !== 16'd4 || s_ready !== 1'b0 ||
          fma_in_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_hold: got %0d unstable cycles (d=%h c=%0d rdy=%b) want 0", bad, m_data, m_count, s_ready);
    end
    accept();
    push(TWO, THR, 1'b1, w);
    wait_result(got);
    checks++;
    if (!got || m_data !== 16'h4600 || m_count !== 16'd1) begin
      failures++; $display("FAIL bp_next: got v=%b d=%h c=%0d want 1/4600/1", m_valid, m_data, m_count);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    int w;
    bit got;
    for (int i = 0; i < 3; i++) push(ONE, ONE, 1'b0, w);
    rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, fma_in_valid, fma_a, fma_b, fma_c, m_valid, m_data, m_count, err} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got rdy=%b iv=%b mv=%b md=%h mc=%0d err=%b want all 0",
               s_ready, fma_in_valid, m_valid, m_data, m_count, err);
    end
    @(negedge clk);
    rst = 1'b0;
    push(ONE, ONE, 1'b0, w);
    push(ONE, ONE, 1'b1, w);
    wait_result(got);
    checks++;
    if (!got || m_data !== 16'h4000 || m_count !== 16'd2) begin
      failures++; $display("FAIL midreset_vec: got v=%b d=%h c=%0d want 1/4000/2", m_valid, m_data, m_count);
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL midreset_err: got %b want 0", err); end
    accept();
  endtask

  task automatic test_spurious();
    int w;
    bit got;
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL spur_pre: got err=%b want 0", err); end
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL spur_set: got err=%b want 1", err); end
    push(ONE, ONE, 1'b1, w);
    wait_result(got);
    accept();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL spur_sticky: got err=%b want 1", err); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL spur_clear: got err=%b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_toggle();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
